sram_arbiter: RTL and testbench

- Two-port sequencer that shares the single asynchronous SRAM between the SLC-3 CPU memory interface (MAR/MDR path) and a debug/loader port.
- Serializes requests, generates the multi-cycle Mem_OE/Mem_WE strobes, registers read data per port, and returns a one-cycle done pulse.
- Sits between the CPU datapath/ISDU memory states and the top-level SRAM pins. This removes fixed SRAM wait states from the ISDU.

---
 rtl/sram_arbiter_if.sv | 15 +
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - request/response port bundle for one SRAM arbiter client
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;

    modport master (output req, we, addr, wdata, input rdata, done);
    modport slave  (input req, we, addr, wdata, output rdata, done);
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin CPU/debug sequencer for the shared asynchronous SRAM
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     cpu,
    sram_arbiter_if.slave     dbg,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_drive,
    input  logic [DATA_W-1:0] sram_din,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_we_q, op_we_d;
    logic              gnt_dbg_q, gnt_dbg_d;
    logic              last_dbg_q, last_dbg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              oe_q, oe_d, we_q, we_d, drive_q, drive_d;
    logic              cpu_done_q, cpu_done_d, dbg_done_q, dbg_done_d;
    logic              pick_dbg;

    // DBG wins only when CPU is idle or CPU was the previous grantee
    assign pick_dbg = dbg.req && (!cpu.req || !last_dbg_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_we_d     = op_we_q;
        gnt_dbg_d   = gnt_dbg_q;
        last_dbg_d  = last_dbg_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        oe_d        = oe_q;
        we_d        = we_q;
        drive_d     = drive_q;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                oe_d    = 1'b1;
                we_d    = 1'b1;
                drive_d = 1'b0;
                if (cpu.req || dbg.req) begin
                    gnt_dbg_d  = pick_dbg;
                    last_dbg_d = pick_dbg;
                    op_we_d    = pick_dbg ? dbg.we    : cpu.we;
                    addr_d     = pick_dbg ? dbg.addr  : cpu.addr;
                    dout_d     = pick_dbg ? dbg.wdata : cpu.wdata;
                    cnt_d      = CNT_INIT;
                    oe_d       = op_we_d;
                    we_d       = !op_we_d;
                    drive_d    = op_we_d;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'd0;
                    oe_d    = 1'b1;
                    we_d    = 1'b1;
                    state_d = DONE;
                    if (!op_we_q) begin
                        if (gnt_dbg_q) dbg_rdata_d = sram_din;
                        else           cpu_rdata_d = sram_din;
                    end
                    cpu_done_d = !gnt_dbg_q;
                    dbg_done_d = gnt_dbg_q;
                end
            end
            DONE: begin
                // write data was held through this cycle for SRAM hold time
                drive_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_we_q     <= 1'b0;
            gnt_dbg_q   <= 1'b0;
            last_dbg_q  <= 1'b1;
            addr_q      <= '0;
            dout_q      <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            drive_q     <= 1'b0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            gnt_dbg_q   <= gnt_dbg_d;
            last_dbg_q  <= last_dbg_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            drive_q     <= drive_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign sram_addr  = addr_q;
    assign sram_dout  = dout_q;
    assign sram_drive = drive_q;
    assign Mem_OE     = oe_q;
    assign Mem_WE     = we_q;
    assign Mem_CE     = 1'b0;
    assign Mem_UB     = 1'b0;
    assign Mem_LB     = 1'b0;
    assign cpu.rdata  = cpu_rdata_q;
    assign cpu.done   = cpu_done_q;
    assign dbg.rdata  = dbg_rdata_q;
    assign dbg.done   = dbg_done_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench for sram_arbiter (WAIT_CYCLES 2 and 1 builds)
module tb_sram_arbiter;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        busy, drive, ce, ub, lb, mem_oe, mem_we;
    logic [19:0] s_addr;
    logic [15:0] s_dout, s_din;
    logic        busy2, drive2, ce2, ub2, lb2, mem_oe2, mem_we2;
    logic [19:0] s_addr2;
    logic [15:0] s_dout2, s_din2;
    logic [15:0] mem  [0:255];
    logic [15:0] mem2 [0:255];
    logic        mon_en = 1'b0;
    int          passed = 0;
    int          total  = 0;

    sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) cpu_if ();
    sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) dbg_if ();
    sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) cpu2_if ();
    sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) dbg2_if ();

    always #5 Clk = ~Clk;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .cpu(cpu_if), .dbg(dbg_if), .busy(busy),
        .sram_addr(s_addr), .sram_dout(s_dout), .sram_drive(drive), .sram_din(s_din),
        .Mem_CE(ce), .Mem_UB(ub), .Mem_LB(lb), .Mem_OE(mem_oe), .Mem_WE(mem_we)
    );

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .cpu(cpu2_if), .dbg(dbg2_if), .busy(busy2),
        .sram_addr(s_addr2), .sram_dout(s_dout2), .sram_drive(drive2), .sram_din(s_din2),
        .Mem_CE(ce2), .Mem_UB(ub2), .Mem_LB(lb2), .Mem_OE(mem_oe2), .Mem_WE(mem_we2)
    );

    // Asynchronous SRAM models: combinational read, write latched on the WE rising edge
    assign s_din  = mem[s_addr[7:0]];
    assign s_din2 = mem2[s_addr2[7:0]];
    always @(posedge mem_we)  mem[s_addr[7:0]]   = s_dout;
    always @(posedge mem_we2) mem2[s_addr2[7:0]] = s_dout2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            chk("excl", {29'd0, !mem_oe && !mem_we, drive && !mem_oe, cpu_if.done && dbg_if.done}, 32'd0);
            chk("excl1", {29'd0, !mem_oe2 && !mem_we2, drive2 && !mem_oe2, cpu2_if.done && dbg2_if.done}, 32'd0);
        end
    end

    initial begin
        Reset = 1'b1;
        cpu_if.req = 0;  cpu_if.we = 0;  cpu_if.addr = 0;  cpu_if.wdata = 0;
        dbg_if.req = 0;  dbg_if.we = 0;  dbg_if.addr = 0;  dbg_if.wdata = 0;
        cpu2_if.req = 0; cpu2_if.we = 0; cpu2_if.addr = 0; cpu2_if.wdata = 0;
        dbg2_if.req = 0; dbg2_if.we = 0; dbg2_if.addr = 0; dbg2_if.wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem[8'h34]  = 16'h1234;
        mem2[8'h07] = 16'h7777;
        step();
        step();

        chk("rst_oe", mem_oe, 1);
        chk("rst_we", mem_we, 1);
        chk("rst_drive", drive, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_dout", s_dout, 0);
        chk("rst_cpu_rdata", cpu_if.rdata, 0);
        chk("rst_dbg_rdata", dbg_if.rdata, 0);
        chk("rst_dones", {cpu_if.done, dbg_if.done}, 0);
        chk("rst_ce_ub_lb", {ce, ub, lb}, 0);
        Reset = 1'b0;
        mon_en = 1'b1;
        step();

        // CPU write 0xBEEF -> 0x00012
        cpu_if.we = 1; cpu_if.addr = 20'h00012; cpu_if.wdata = 16'hBEEF; cpu_if.req = 1;
        step();
        chk("wr1_we", mem_we, 0);
        chk("wr1_oe", mem_oe, 1);
        chk("wr1_addr", s_addr, 20'h00012);
        chk("wr1_dout", s_dout, 16'hBEEF);
        chk("wr1_drive", drive, 1);
        chk("wr1_busy", busy, 1);
        chk("wr1_done", cpu_if.done, 0);
        cpu_if.addr = 20'h00055; cpu_if.wdata = 16'h0000;
        step();
        chk("wr2_we", mem_we, 0);
        chk("wr2_addr_hold", s_addr, 20'h00012);
        chk("wr2_dout_hold", s_dout, 16'hBEEF);
        chk("wr2_done", cpu_if.done, 0);
        step();
        chk("wr3_we", mem_we, 1);
        chk("wr3_cpu_done", cpu_if.done, 1);
        chk("wr3_dbg_done", dbg_if.done, 0);
        chk("wr3_drive_hold", drive, 1);
        cpu_if.req = 0;
        step();
        chk("wr4_done", cpu_if.done, 0);
        chk("wr4_busy", busy, 0);
        chk("wr4_drive", drive, 0);
        chk("wr_rdata_untouched", cpu_if.rdata, 0);
        chk("sram_written", mem[8'h12], 16'hBEEF);

        // CPU read of 0x00012
        cpu_if.we = 0; cpu_if.addr = 20'h00012; cpu_if.req = 1;
        step();
        chk("rd1_oe", mem_oe, 0);
        chk("rd1_we", mem_we, 1);
        chk("rd1_drive", drive, 0);
        step();
        chk("rd2_oe", mem_oe, 0);
        chk("rd2_done", cpu_if.done, 0);
        step();
        chk("rd3_oe", mem_oe, 1);
        chk("rd3_done", cpu_if.done, 1);
        chk("rd3_cpu_rdata", cpu_if.rdata, 16'hBEEF);
        chk("rd3_dbg_rdata", dbg_if.rdata, 0);
        cpu_if.req = 0;
        step();
        chk("rd4_busy", busy, 0);
        chk("rd4_rdata_hold", cpu_if.rdata, 16'hBEEF);

        // Simultaneous requests after reset: CPU, DBG, CPU, DBG
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        cpu_if.we = 0; cpu_if.addr = 20'h00012;
        dbg_if.we = 0; dbg_if.addr = 20'h00034;
        cpu_if.req = 1; dbg_if.req = 1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("rr_cpu_done_%0d", k), cpu_if.done, (k == 3 || k == 11) ? 1 : 0);
            chk($sformatf("rr_dbg_done_%0d", k), dbg_if.done, (k == 7 || k == 15) ? 1 : 0);
            if (k == 1 || k == 9)  chk($sformatf("rr_addr_%0d", k), s_addr, 20'h00012);
            if (k == 5 || k == 13) chk($sformatf("rr_addr_%0d", k), s_addr, 20'h00034);
            if (k == 3)  chk("rr_cpu_rdata", cpu_if.rdata, 16'hBEEF);
            if (k == 7)  chk("rr_dbg_rdata", dbg_if.rdata, 16'h1234);
            if (k == 15) begin
                cpu_if.req = 0;
                dbg_if.req = 0;
            end
            if (k == 16) chk("rr_idle", busy, 0);
        end

        // DBG request arrives during a CPU write
        cpu_if.we = 1; cpu_if.addr = 20'h00040; cpu_if.wdata = 16'hA5A5; cpu_if.req = 1;
        step();
        chk("ov1_we", mem_we, 0);
        dbg_if.we = 0; dbg_if.addr = 20'h00040; dbg_if.req = 1;
        step();
        chk("ov2_addr", s_addr, 20'h00040);
        chk("ov2_dout", s_dout, 16'hA5A5);
        chk("ov2_dbg_done", dbg_if.done, 0);
        step();
        chk("ov3_cpu_done", cpu_if.done, 1);
        chk("ov3_dbg_done", dbg_if.done, 0);
        cpu_if.req = 0;
        step();
        chk("ov4_idle", busy, 0);
        step();
        chk("ov5_oe", mem_oe, 0);
        chk("ov5_addr", s_addr, 20'h00040);
        chk("ov5_drive", drive, 0);
        step();
        step();
        chk("ov7_dbg_done", dbg_if.done, 1);
        chk("ov7_cpu_done", cpu_if.done, 0);
        chk("ov7_dbg_rdata", dbg_if.rdata, 16'hA5A5);
        chk("ov7_cpu_rdata", cpu_if.rdata, 16'hBEEF);
        dbg_if.req = 0;
        step();
        chk("ov8_idle", busy, 0);

        // Reset in the second ACCESS cycle of a write
        cpu_if.we = 1; cpu_if.addr = 20'h00050; cpu_if.wdata = 16'h1111; cpu_if.req = 1;
        step();
        chk("ra1_we", mem_we, 0);
        step();
        chk("ra2_we", mem_we, 0);
        Reset = 1'b1;
        cpu_if.req = 0;
        step();
        chk("ra_we", mem_we, 1);
        chk("ra_drive", drive, 0);
        chk("ra_dones", {cpu_if.done, dbg_if.done}, 0);
        chk("ra_busy", busy, 0);
        chk("ra_cpu_rdata", cpu_if.rdata, 0);
        chk("ra_dbg_rdata", dbg_if.rdata, 0);
        Reset = 1'b0;
        step();
        chk("ra_no_late_done", cpu_if.done, 0);

        // WAIT_CYCLES = 1 build: read of 0x00007
        cpu2_if.we = 0; cpu2_if.addr = 20'h00007; cpu2_if.req = 1;
        step();
        chk("w1_oe1", mem_oe2, 0);
        chk("w1_done1", cpu2_if.done, 0);
        step();
        chk("w1_oe2", mem_oe2, 1);
        chk("w1_done2", cpu2_if.done, 1);
        chk("w1_rdata", cpu2_if.rdata, 16'h7777);
        cpu2_if.req = 0;
        step();
        chk("w1_idle", busy2, 0);
        chk("w1_done3", cpu2_if.done, 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
